// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver: FSM states,
// 2-bit {j,k} codes and the transition encoder.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } jk_state_e;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] TGL  = 2'b11;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_CNT_W = 8;

  // {j,k} needed to move a JK flip-flop from q_pred to tgt.
  function automatic logic [1:0] jk_encode(input logic q_pred, input logic tgt,
                                           input logic toggle_en);
    logic [1:0] code;
    if (q_pred == tgt) begin
      code = HOLD;
    end else if (toggle_en) begin
      code = TGL;
    end else begin
      code = tgt ? SET : RST;
    end
    return code;
  endfunction

endpackage

// File: rtl/jk_excitation_driver_fifo.sv
// One-bit-wide FIFO of target bits. A push while full is refused even when a
// pop happens on the same edge; pointers wrap modulo DEPTH (power of two).
module jk_bit_fifo
  import jk_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       din_i,
  input  logic                       pop_i,
  output logic                       dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Turns a stream of desired flip-flop values into registered J/K pulses for a
// downstream JK flip-flop, then checks the flop's q one cycle later.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int CNT_W     = DEFAULT_CNT_W,
  parameter bit TOGGLE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output jk_state_e        dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a target bit transfers on a rising edge where tgt_valid and
  // tgt_ready are both high; tgt_ready depends only on FIFO fullness and rst.
  jk_state_e        state_q, state_d;
  logic             j_q, j_d, k_q, k_d;
  logic             hold_q, hold_d;
  logic             q_pred_q, q_pred_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop;
  logic             fifo_full, fifo_empty, fifo_dout;
  logic [CW-1:0]    fifo_count;

  jk_bit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tgt_valid),
    .din_i   (tgt_bit),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    j_d      = 1'b0;
    k_d      = 1'b0;
    hold_d   = hold_q;
    q_pred_d = q_pred_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          hold_d       = fifo_dout;
          {j_d, k_d}   = jk_encode(q_pred_q, fifo_dout, TOGGLE_EN);
          state_d      = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb != hold_q) begin
          err_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        // Encode the next bit from what the flop actually holds now.
        q_pred_d = q_fb;
        if (!fifo_empty) begin
          pop        = 1'b1;
          hold_d     = fifo_dout;
          {j_d, k_d} = jk_encode(q_fb, fifo_dout, TOGGLE_EN);
          state_d    = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
      hold_q   <= 1'b0;
      q_pred_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      k_q      <= k_d;
      hold_q   <= hold_d;
      q_pred_q <= q_pred_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tgt_ready = !fifo_full && !rst;
  assign j         = j_q;
  assign k         = k_q;
  assign busy      = (fifo_count != '0) || (state_q != IDLE);
  assign err       = err_q;
  assign err_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: three parameterisations share one stimulus
// stream, each paired with a JK flop model and a queue-based reference model.
module tb_jk_excitation_driver;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tgt_valid = 1'b0;
  logic tgt_bit = 1'b0;
  logic stuck = 1'b0;

  logic [2:0] ready_w, j_w, k_w, busy_w, err_w;
  logic [2:0] q_ff = 3'b000;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  jk_pkg::jk_state_e st0, st1, st2;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state, index 0: set/reset, 1: toggle, 2: CNT_W=2
  bit         mf[3][$];
  int         m_age[3];
  bit         m_hold[3], m_qpred[3], m_q[3], m_j[3], m_k[3], m_err[3];
  int         m_cnt[3];
  int         m_acc;
  logic [1:0] log_q[3][$];
  logic [1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(8), .TOGGLE_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready_w[0]),
    .j(j_w[0]), .k(k_w[0]), .q_fb(q_ff[0]), .busy(busy_w[0]), .err(err_w[0]),
    .err_cnt(cnt0), .dbg_state(st0));
  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(8), .TOGGLE_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready_w[1]),
    .j(j_w[1]), .k(k_w[1]), .q_fb(q_ff[1]), .busy(busy_w[1]), .err(err_w[1]),
    .err_cnt(cnt1), .dbg_state(st1));
  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(2), .TOGGLE_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready_w[2]),
    .j(j_w[2]), .k(k_w[2]), .q_fb(q_ff[2]), .busy(busy_w[2]), .err(err_w[2]),
    .err_cnt(cnt2), .dbg_state(st2));

  function automatic bit jk_next(input bit q, input bit jj, input bit kk);
    case ({jj, kk})
      2'b00:   return q;
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      default: return !q;
    endcase
  endfunction

  // downstream JK flip-flops, optionally stuck at 0
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      q_ff[i] <= (rst || stuck) ? 1'b0 : jk_next(q_ff[i], j_w[i], k_w[i]);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // age: 0 = nothing in flight, 1 = j/k just presented, 2 = due for checking
  task automatic model_step(input int i);
    bit q_pre;
    bit push_ok;
    bit can_pop;
    int cmax;
    cmax = (i == 2) ? 3 : 255;
    if (rst) begin
      mf[i].delete();
      m_age[i] = 0; m_hold[i] = 0; m_qpred[i] = 0; m_q[i] = 0;
      m_j[i] = 0; m_k[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
      return;
    end
    q_pre   = m_q[i];
    push_ok = tgt_valid && (mf[i].size() < DEPTH);
    can_pop = (mf[i].size() > 0) && (m_age[i] != 1);
    m_q[i]  = stuck ? 1'b0 : jk_next(q_pre, m_j[i], m_k[i]);
    m_j[i]  = 0;
    m_k[i]  = 0;
    if (m_age[i] == 2) begin
      if (q_pre != m_hold[i]) begin
        m_err[i] = 1;
        if (m_cnt[i] < cmax) m_cnt[i]++;
      end
      m_qpred[i] = q_pre;
      m_age[i]   = 0;
    end else if (m_age[i] == 1) begin
      m_age[i] = 2;
    end
    if (can_pop) begin
      m_hold[i] = mf[i].pop_front();
      if (m_hold[i] != m_qpred[i]) begin
        m_j[i] = (i == 1) ? 1'b1 : m_hold[i];
        m_k[i] = (i == 1) ? 1'b1 : !m_hold[i];
      end
      m_age[i] = 1;
      log_q[i].push_back({m_j[i], m_k[i]});
    end
    if (push_ok) begin
      mf[i].push_back(tgt_bit);
      if (i == 0) m_acc++;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  // scoreboard: every output of every instance against the model each cycle
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("j[%0d]", i), int'(j_w[i]), int'(m_j[i]));
      chk($sformatf("k[%0d]", i), int'(k_w[i]), int'(m_k[i]));
      chk($sformatf("busy[%0d]", i), int'(busy_w[i]), int'(mf[i].size() > 0 || m_age[i] != 0));
      chk($sformatf("err[%0d]", i), int'(err_w[i]), int'(m_err[i]));
      chk($sformatf("ready[%0d]", i), int'(ready_w[i]), int'(!rst && mf[i].size() < DEPTH));
    end
    chk("err_cnt[0]", int'(cnt0), m_cnt[0]);
    chk("err_cnt[1]", int'(cnt1), m_cnt[1]);
    chk("err_cnt[2]", int'(cnt2), m_cnt[2]);
  end

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_bit(input bit b);
    tgt_valid = 1'b1;
    tgt_bit   = b;
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_w[0] && n < 60) begin
      tick();
      n++;
    end
    chk("drain_in_time", int'(n < 60), 1);
    chk("idle_state0", int'(st0), int'(jk_pkg::IDLE));
    chk("idle_state1", int'(st1), int'(jk_pkg::IDLE));
    chk("idle_state2", int'(st2), int'(jk_pkg::IDLE));
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) log_q[i].delete();
  endtask

  task automatic chk_log(input int i, input string name);
    chk({name, "_len"}, log_q[i].size(), exp_q.size());
    for (int n = 0; n < exp_q.size() && n < log_q[i].size(); n++) begin
      chk($sformatf("%s_%0d", name, n), int'(log_q[i][n]), int'(exp_q[n]));
    end
  endtask

  initial begin
    bit seen_not_ready;
    bit found;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_busy", int'(busy_w[0]), 0);
    chk("rst_ready", int'(ready_w[0]), 0);
    chk("rst_jk", int'({j_w[0], k_w[0]}), 0);
    chk("rst_cnt", int'(cnt0), 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(ready_w[0]), 1);

    // stream 1,0,1,1 in both encodings
    clear_logs();
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
    wait_idle();
    exp_q = '{2'b10, 2'b01, 2'b10, 2'b00};
    chk_log(0, "setrst_seq");
    exp_q = '{2'b11, 2'b11, 2'b11, 2'b00};
    chk_log(1, "toggle_seq");
    chk("seq_err0", int'(err_w[0]), 0);
    chk("seq_err1", int'(err_w[1]), 0);
    chk("seq_cnt0", int'(cnt0), 0);
    chk("seq_busy", int'(busy_w[0]), 0);

    // hold tgt_valid for 12 cycles from idle: FIFO fills and refuses pushes
    clear_logs();
    m_acc = 0;
    seen_not_ready = 1'b0;
    tgt_valid = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tgt_bit = 1'($urandom_range(0, 1));
      tick();
      if (!ready_w[0]) seen_not_ready = 1'b1;
    end
    tgt_valid = 1'b0;
    wait_idle();
    chk("fill_accepted", m_acc, 9);
    chk("fill_driven", log_q[0].size(), 9);
    chk("fill_saw_full", int'(seen_not_ready), 1);

    // reset while a bit is being driven with three more queued
    found = 1'b0;
    tgt_valid = 1'b1;
    for (int n = 0; n < 20 && !found; n++) begin
      tgt_bit = 1'($urandom_range(0, 1));
      tick();
      if (m_age[0] == 1 && mf[0].size() == 3) found = 1'b1;
    end
    tgt_valid = 1'b0;
    chk("reach_drive_q3", int'(found), 1);
    rst = 1'b1;
    tick();
    chk("midrst_jk", int'({j_w[0], k_w[0]}), 0);
    chk("midrst_busy", int'(busy_w[0]), 0);
    chk("midrst_ready", int'(ready_w[0]), 0);
    chk("midrst_err", int'(err_w[0]), 0);
    rst = 1'b0;
    clear_logs();
    push_bit(1'b1);
    wait_idle();
    exp_q = '{2'b10};
    chk_log(0, "postrst_seq");

    // flop stuck at 0: 1,1,0 gives two mismatches
    stuck = 1'b1;
    reset_pulse();
    push_bit(1'b1); push_bit(1'b1); push_bit(1'b0);
    wait_idle();
    chk("stuck_err", int'(err_w[0]), 1);
    chk("stuck_cnt0", int'(cnt0), 2);
    chk("stuck_cnt1", int'(cnt1), 2);

    // five mismatches saturate the 2-bit counter
    reset_pulse();
    for (int n = 0; n < 5; n++) push_bit(1'b1);
    wait_idle();
    chk("sat_cnt2", int'(cnt2), 3);
    chk("sat_cnt0", int'(cnt0), 5);
    stuck = 1'b0;
    reset_pulse();

    // random traffic with occasional stuck-flop episodes and resets
    for (int n = 0; n < 3000; n++) begin
      tgt_valid = ($urandom_range(0, 99) < 60);
      tgt_bit   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) stuck = !stuck;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tgt_valid = 1'b0;
    stuck = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
